sm_ctrl: RTL and testbench

- Instruction-sequencing controller that sits directly upstream of the datapath and drives all of its control inputs.
- Latches a 16-bit instruction on a start handshake and decodes it.
- Steps a Moore FSM through register-fetch, execute and write-back.
- Raises w when it is idle and ready for the next instruction.
- Supported operations: MOV immediate, MOV register, ADD, CMP, AND, MVN.

---
 rtl/sm_pkg.sv | 55 +++++
 rtl/sm_if.sv | 38 +++
 rtl/sm_decode.sv | 45 ++++
 rtl/sm_ctrl.sv | 128 ++++++++++++
 tb/tb_sm_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/sm_pkg.sv
// Shared types and constants for the instruction-sequencing controller.
//   state_e  : controller FSM states
//   cls_e    : decoded instruction class
//   OPC_*/OP_* : opcode and op field encodings
//   ALU_*/SHIFT_* : datapath control codes
//   sext()   : sign-extend the low w bits of a 32-bit value
package sm_pkg;

  typedef enum logic [2:0] {
    StWait,
    StDecode,
    StGetA,
    StGetB,
    StExec,
    StWReg,
    StWImm
  } state_e;

  typedef enum logic [2:0] {
    ClsIllegal,
    ClsMovImm,
    ClsMovReg,
    ClsAdd,
    ClsCmp,
    ClsAnd,
    ClsMvn
  } cls_e;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  localparam logic [1:0] SHIFT_NONE = 2'b00;

  // Bits at and above position w are replaced by bit w-1.
  function automatic logic [31:0] sext(input logic [31:0] v, input int unsigned w);
    logic [31:0] low_mask;
    logic        sign;
    low_mask = (32'h1 << w) - 32'h1;
    sign     = |(v & (32'h1 << (w - 1)));
    return sign ? (v | ~low_mask) : (v & low_mask);
  endfunction

endpackage

// File: rtl/sm_if.sv
// Handshake and datapath-control bundle between the upstream instruction
// source, the sm_ctrl controller and the datapath.
//   master : drives s/instr, observes every controller output
//   slave  : the controller; samples s/instr, drives w/illegal and all
//            datapath control signals
interface sm_if #(
  parameter int unsigned IW = 16
);
  logic          s;
  logic [IW-1:0] instr;
  logic          w;
  logic          illegal;
  logic [2:0]    readnum;
  logic [2:0]    writenum;
  logic          write;
  logic          vsel;
  logic          loada;
  logic          loadb;
  logic          asel;
  logic          bsel;
  logic [1:0]    shift;
  logic [1:0]    ALUop;
  logic          loadc;
  logic          loads;
  logic [IW-1:0] datapath_in;

  modport master (
    output s, instr,
    input  w, illegal, readnum, writenum, write, vsel, loada, loadb,
           asel, bsel, shift, ALUop, loadc, loads, datapath_in
  );

  modport slave (
    input  s, instr,
    output w, illegal, readnum, writenum, write, vsel, loada, loadb,
           asel, bsel, shift, ALUop, loadc, loads, datapath_in
  );
endinterface

// File: rtl/sm_decode.sv
// Pure combinational instruction decoder.
//   ir_i  : latched instruction word
//   cls_o : instruction class (ClsIllegal for undefined {opcode,op})
//   rn_o/rd_o/rm_o : register fields, sh_o : shift field, op_o : op field
//   imm_o : imm8 sign-extended to IW
module sm_decode
  import sm_pkg::*;
#(
  parameter int unsigned IW   = 16,
  parameter int unsigned IMMW = 8
) (
  input  logic [IW-1:0] ir_i,
  output cls_e          cls_o,
  output logic [2:0]    rn_o,
  output logic [2:0]    rd_o,
  output logic [2:0]    rm_o,
  output logic [1:0]    sh_o,
  output logic [1:0]    op_o,
  output logic [IW-1:0] imm_o
);

  logic [2:0] opcode;

  assign opcode = ir_i[15:13];
  assign op_o   = ir_i[12:11];
  assign rn_o   = ir_i[10:8];
  assign rd_o   = ir_i[7:5];
  assign sh_o   = ir_i[4:3];
  assign rm_o   = ir_i[2:0];
  assign imm_o  = IW'(sext(32'(ir_i[IMMW-1:0]), IMMW));

  always_comb begin
    cls_o = ClsIllegal;
    case ({opcode, op_o})
      {OPC_MOV, OP_MOV_IMM}: cls_o = ClsMovImm;
      {OPC_MOV, OP_MOV_REG}: cls_o = ClsMovReg;
      {OPC_ALU, OP_ADD}:     cls_o = ClsAdd;
      {OPC_ALU, OP_CMP}:     cls_o = ClsCmp;
      {OPC_ALU, OP_AND}:     cls_o = ClsAnd;
      {OPC_ALU, OP_MVN}:     cls_o = ClsMvn;
      default:               cls_o = ClsIllegal;
    endcase
  end

endmodule

// File: rtl/sm_ctrl.sv
// Instruction-sequencing controller. Latches an instruction on the start
// handshake in StWait and steps a Moore FSM through register fetch, execute
// and write-back, driving every datapath control input.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : sm_if slave (s/instr in; w, illegal and datapath controls out)
// All outputs depend only on state_q and ir_q.
module sm_ctrl
  import sm_pkg::*;
#(
  parameter int unsigned IW   = 16,
  parameter int unsigned IMMW = 8
) (
  input  logic clk,
  input  logic rst_n,
  sm_if.slave  bus
);

  state_e        state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;

  cls_e          cls;
  logic [2:0]    rn, rd, rm;
  logic [1:0]    sh, op;
  logic [IW-1:0] imm;

  sm_decode #(
    .IW   (IW),
    .IMMW (IMMW)
  ) u_decode (
    .ir_i  (ir_q),
    .cls_o (cls),
    .rn_o  (rn),
    .rd_o  (rd),
    .rm_o  (rm),
    .sh_o  (sh),
    .op_o  (op),
    .imm_o (imm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StWait;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      StWait: begin
        if (bus.s) begin
          ir_d    = bus.instr;
          state_d = StDecode;
        end
      end
      StDecode: begin
        case (cls)
          ClsMovImm:                state_d = StWImm;
          ClsMovReg, ClsMvn:        state_d = StGetB;
          ClsAdd, ClsCmp, ClsAnd:   state_d = StGetA;
          default:                  state_d = StWait;
        endcase
      end
      StGetA:  state_d = StGetB;
      StGetB:  state_d = StExec;
      // CMP only updates status, so it skips write-back.
      StExec:  state_d = (cls == ClsCmp) ? StWait : StWReg;
      StWReg:  state_d = StWait;
      StWImm:  state_d = StWait;
      default: state_d = StWait;
    endcase
  end

  always_comb begin
    bus.w           = 1'b0;
    bus.illegal     = 1'b0;
    // Register selects idle at Rn/Rd of the current ir so they stay stable.
    bus.readnum     = rn;
    bus.writenum    = rd;
    bus.write       = 1'b0;
    bus.vsel        = 1'b0;
    bus.loada       = 1'b0;
    bus.loadb       = 1'b0;
    bus.asel        = 1'b0;
    bus.bsel        = 1'b0;
    bus.shift       = SHIFT_NONE;
    bus.ALUop       = ALU_ADD;
    bus.loadc       = 1'b0;
    bus.loads       = 1'b0;
    bus.datapath_in = imm;
    case (state_q)
      StWait:   bus.w = 1'b1;
      StDecode: bus.illegal = (cls == ClsIllegal);
      StGetA: begin
        bus.readnum = rn;
        bus.loada   = 1'b1;
      end
      StGetB: begin
        bus.readnum = rm;
        bus.loadb   = 1'b1;
      end
      StExec: begin
        bus.shift = sh;
        bus.ALUop = (cls == ClsMovReg) ? ALU_ADD : op;
        bus.asel  = (cls == ClsMovReg) || (cls == ClsMvn);
        bus.loadc = (cls != ClsCmp);
        bus.loads = (cls == ClsCmp);
      end
      StWReg: begin
        bus.writenum = rd;
        bus.vsel     = 1'b0;
        bus.write    = 1'b1;
      end
      StWImm: begin
        bus.writenum = rn;
        bus.vsel     = 1'b1;
        bus.write    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sm_ctrl.sv
// Directed bench for sm_ctrl with a small register-file/ALU model driven
// by the controller outputs.
module tb_sm_ctrl;
  import sm_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  sm_if #(.IW(16)) bus ();

  sm_ctrl #(
    .IW   (16),
    .IMMW (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Datapath model
  logic [15:0] rf [8];
  logic [15:0] ra, rb, rc, ain, bin, alu_res;
  logic        z;

  always_comb begin
    ain = bus.asel ? 16'h0 : ra;
    bin = rb;
    case (bus.shift)
      2'b01:   bin = {rb[14:0], 1'b0};
      2'b10:   bin = {1'b0, rb[15:1]};
      2'b11:   bin = {rb[15], rb[15:1]};
      default: bin = rb;
    endcase
    case (bus.ALUop)
      2'b00:   alu_res = ain + bin;
      2'b01:   alu_res = ain - bin;
      2'b10:   alu_res = ain & bin;
      default: alu_res = ~bin;
    endcase
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
      ra <= '0;
      rb <= '0;
      rc <= '0;
      z  <= 1'b0;
    end else begin
      if (bus.write) rf[bus.writenum] <= bus.vsel ? bus.datapath_in : rc;
      if (bus.loada) ra <= rf[bus.readnum];
      if (bus.loadb) rb <= rf[bus.readnum];
      if (bus.loadc) rc <= alu_res;
      if (bus.loads) z <= (alu_res == 16'h0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents instr with s=1 for one edge; returns in the decode cycle.
  task automatic issue(input logic [15:0] ins);
    bus.s     = 1'b1;
    bus.instr = ins;
    tick();
    bus.s     = 1'b0;
  endtask

  function automatic logic [31:0] ctl_bits();
    return 32'({bus.illegal, bus.write, bus.vsel, bus.loada, bus.loadb, bus.asel,
                bus.bsel, bus.loadc, bus.loads, bus.shift, bus.ALUop});
  endfunction

  logic wr_seen;

  initial begin
    bus.s     = 1'b0;
    bus.instr = '0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_w", bus.w, 1);
    chk("rst_ctl", ctl_bits(), 0);
    chk("rst_regsel", {bus.readnum, bus.writenum}, 0);
    chk("rst_dpin", bus.datapath_in, 0);
    rst_n = 1'b1;
    tick();

    // MOV R0,#50; s held high with another instr during decode is ignored
    issue(16'hD032);
    chk("movi_c1_w", bus.w, 0);
    chk("movi_c1_ill", bus.illegal, 0);
    bus.s     = 1'b1;
    bus.instr = 16'hE000;
    tick();
    bus.s = 1'b0;
    chk("movi_c2_wr", {bus.write, bus.vsel, bus.writenum}, {1'b1, 1'b1, 3'd0});
    chk("movi_c2_dpin", bus.datapath_in, 16'h0032);
    tick();
    chk("movi_c3_w", {bus.w, bus.write}, 2'b10);
    chk("movi_r0", rf[0], 16'h0032);

    // MOV R1,#-3
    issue(16'hD1FD);
    tick();
    chk("movn_dpin", bus.datapath_in, 16'hFFFD);
    chk("movn_wn", bus.writenum, 1);
    tick();
    chk("movn_w", bus.w, 1);
    chk("movn_r1", rf[1], 16'hFFFD);

    // ADD R2,R0,R1
    issue(16'hA041);
    tick();
    chk("add_geta", {bus.readnum, bus.loada, bus.loadb}, {3'd0, 1'b1, 1'b0});
    tick();
    chk("add_getb", {bus.readnum, bus.loada, bus.loadb}, {3'd1, 1'b0, 1'b1});
    tick();
    chk("add_exec", {bus.ALUop, bus.loadc, bus.loads, bus.asel}, {2'b00, 1'b1, 1'b0, 1'b0});
    tick();
    chk("add_wreg", {bus.writenum, bus.write, bus.vsel}, {3'd2, 1'b1, 1'b0});
    tick();
    chk("add_w", bus.w, 1);
    chk("add_r2", rf[2], 16'h002F);

    // CMP R0,R1: no write, back to idle after four edges
    wr_seen = 1'b0;
    issue(16'hA801);
    wr_seen |= bus.write;
    tick();
    wr_seen |= bus.write;
    tick();
    wr_seen |= bus.write;
    tick();
    wr_seen |= bus.write;
    chk("cmp_exec", {bus.loads, bus.ALUop, bus.loadc}, {1'b1, 2'b01, 1'b0});
    chk("cmp_w_early", bus.w, 0);
    tick();
    chk("cmp_w", {bus.w, bus.write}, 2'b10);
    chk("cmp_nowrite", wr_seen, 0);
    chk("cmp_z", z, 0);

    // Undefined opcode
    issue(16'hE000);
    chk("ill_pulse", bus.illegal, 1);
    chk("ill_noload", {bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads}, 0);
    tick();
    chk("ill_end", {bus.w, bus.illegal}, 2'b10);

    // MVN R3,R1 LSL
    issue(16'hB869);
    tick();
    chk("mvn_getb", {bus.readnum, bus.loadb, bus.loada}, {3'd1, 1'b1, 1'b0});
    tick();
    chk("mvn_exec", {bus.asel, bus.ALUop, bus.shift, bus.loadc}, {1'b1, 2'b11, 2'b01, 1'b1});
    tick();
    chk("mvn_wreg", {bus.writenum, bus.write}, {3'd3, 1'b1});
    tick();
    chk("mvn_w", bus.w, 1);
    chk("mvn_r3", rf[3], 16'h0005);

    // MOV R4,R0 LSR
    issue(16'hC090);
    tick();
    tick();
    chk("movr_exec", {bus.asel, bus.ALUop, bus.shift}, {1'b1, 2'b00, 2'b10});
    tick();
    chk("movr_wreg", {bus.writenum, bus.write}, {3'd4, 1'b1});
    tick();
    chk("movr_w", bus.w, 1);
    chk("movr_r4", rf[4], 16'h0019);

    // AND R5,R0,R1
    issue(16'hB0A1);
    repeat (3) tick();
    chk("and_exec", {bus.ALUop, bus.asel}, {2'b10, 1'b0});
    tick();
    chk("and_w_early", bus.w, 0);
    tick();
    chk("and_w", bus.w, 1);
    chk("and_r5", rf[5], 16'h0030);

    // CMP R2,R2 sets Z
    issue(16'hAA02);
    repeat (4) tick();
    chk("cmp2_z", z, 1);

    // Reset in the middle of ADD execute
    issue(16'hA041);
    repeat (3) tick();
    chk("rst_pre_exec", bus.loadc, 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_w", bus.w, 1);
    chk("rstmid_ctl", ctl_bits(), 0);
    chk("rstmid_regsel", {bus.readnum, bus.writenum}, 0);
    chk("rstmid_dpin", bus.datapath_in, 0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    wr_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      wr_seen |= bus.write;
    end
    chk("rstmid_nowrite", wr_seen, 0);
    chk("rstmid_idle", bus.w, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
